tri_scan_unit: RTL and testbench
================================

# tri_scan_unit

Sequential, parametrised rasteriser core built on the three-edge-function inside test. It accepts one triangle per handshake, derives a screen-clamped bounding box, and scans the box row-major at one pixel per cycle. Edge values are updated incrementally with adders rather than six multiplies per pixel. Covered pixels are emitted on a valid/ready stream to the downstream shading/framebuffer stage, and the unit also reports a completion pulse and a pixel count.

## Interface
- COORD_W, 16: signed integer pixel-coordinate width of the vertex inputs.
- SCREEN_W, 320: screen width in pixels; x is clamped to [0, SCREEN_W-1].
- SCREEN_H, 240: screen height in pixels; y is clamped to [0, SCREEN_H-1].
- CULL_BACK, 1: 1 means only positive-area triangles are rasterised and others are dropped; 0 means negative-area triangles are also rasterised, with edges negated.
- Derived: E_W = 2*COORD_W+4 (edge accumulator width); XW/YW = clog2(SCREEN_W)/clog2(SCREEN_H); CNT_W = clog2(SCREEN_W*SCREEN_H+1).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tri_valid  in  1  triangle offered.
- tri_ready  out  1  unit is in IDLE and can accept a triangle.
- v0x, v0y, v1x, v1y, v2x, v2y  in  COORD_W each  signed vertex coordinates; sampled only on accept.
- pix_valid  out  1  pix_x/pix_y hold a covered pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  XW  pixel x (unsigned).
- pix_y  out  YW  pixel y (unsigned).
- done  out  1  one-cycle pulse when the triangle is finished.
- pix_count  out  CNT_W  number of pixels emitted for the last or current triangle; final value is valid when done=1.

## Operation
- The FSM has five states: IDLE, SETUP, INIT, SCAN, DONE.
- IDLE
  - tri_ready=1.
  - Accept when tri_valid&tri_ready: latch the vertices, clear pix_count, go to SETUP.
- SETUP
  - Register the bounding box: min/max of the vertices, clamped to the screen.
  - Register the step coefficients per edge i→j: A = vjy−viy (x step) and B = −(vjx−vix) (y step). Differences are COORD_W+1 bits, sign-extended to E_W.
  - Register area = (v2x−v0x)(v1y−v0y) − (v2y−v0y)(v1x−v0x).
  - Go to INIT.
- INIT
  - Compute each edge at (xmin, ymin): E = (px−vix)(vjy−viy) − (py−viy)(vjx−vix), full-precision signed, in E_W bits.
  - Load both the current-edge and the row-start registers.
  - If CULL_BACK=0 and area<0, negate all three E, A and B.
  - Go to DONE (zero pixels) if area==0 (degenerate), or area<0 with CULL_BACK=1, or the box is empty after clamping (xmax<xmin or ymax<ymin).
  - Otherwise go to SCAN.
- SCAN: the current pixel is covered when all three E>=0. Boundaries are inclusive, matching the existing inside test.
  - pix_valid = covered. pix_x/pix_y = current coordinates. These are decoded from registered state only, with no combinational path from pix_ready.
  - The pixel advances when the current pixel is not covered, or when pix_valid&pix_ready. Otherwise all state holds.
  - Each emitted pixel increments pix_count.
  - Advance within a row: x+1, E += A.
  - Advance at x==xmax: x = xmin, row-start E += B, current E = new row-start, y+1.
  - Advancing from (xmax, ymax) goes to DONE.
- DONE
  - done=1 for exactly one cycle, then IDLE.
- Reset
  - All registers clear asynchronously and the FSM enters IDLE.
  - Output values during and after reset: tri_ready=1, pix_valid=0, done=0, pix_x=pix_y=0, pix_count=0.
  - Asserting reset mid-triangle aborts it: no done pulse, and pixels already emitted are not retracted.
- There is no overflow within E_W for any in-range vertex/box combination.

## Timing
- Accept at cycle T; SETUP at T+1; INIT at T+2; the first SCAN pixel is presented at T+3.
- Without stalls, one pixel is evaluated per cycle. For a box of W×H pixels: done at T+3+W*H, tri_ready=1 at T+4+W*H.
- A triangle that is culled, degenerate or has an empty box: done at T+3, pix_count=0.
- Each cycle with pix_valid=1 and pix_ready=0 adds exactly one cycle. pix_x, pix_y and pix_valid stay stable while stalled.
- tri_ready=0 from T+1 until the cycle after done. A tri_valid held during that time is not accepted.

## Test plan
- Basic coverage: (0,0),(0,8),(8,0), 16×16 screen, pix_ready=1.
  - Required: 45 pixels satisfying x+y<=8, in row-major order.
  - First pixel (0,0), last pixel (0,8).
  - done at T+84, pix_count=45.
- Orientation: swap v1 and v2.
  - With CULL_BACK=1: 0 pixels, done at T+3.
  - With CULL_BACK=0: the identical 45-pixel sequence.
- Backpressure: repeat the basic test with pix_ready high 1 cycle in 3.
  - Same sequence and pix_count=45.
  - Outputs stable during stalls; done delayed by exactly the stall count.
- Clipping: (-4,-4),(-4,20),(20,-4), SCREEN 16×16.
  - Box clamped to 0..15.
  - 151 pixels (x+y<=16), done at T+3+256.
- Degenerate: collinear (0,0),(4,4),(8,8).
  - No pix_valid, done at T+3, pix_count=0.
  - Back-to-back with the basic triangle: the second triangle is accepted at T+4 and is correct.
- Reset mid-scan: assert rst after 10 emitted pixels.
  - Outputs go to reset values immediately; no done pulse.
  - tri_ready=1; the next triangle produces correct results.

Source files
------------

// File: rtl/tri_scan_unit.sv
// -----------------------------------------------------------------------------
// tri_scan_unit
//
// Sequential triangle rasteriser. One triangle is accepted per handshake; the
// unit derives a screen-clamped bounding box, evaluates the three edge
// functions at the box origin, and then walks the box row-major at one pixel
// per cycle. Edge values advance by addition only (A per x step, B per row).
// Covered pixels (all three edges >= 0, boundaries inclusive) are presented on
// a valid/ready stream.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   tri_valid/ready     triangle handshake; ready only while idle
//   v0x..v2y            signed vertex coordinates, sampled on accept
//   pix_valid/ready     covered-pixel stream; pix_x/pix_y hold the pixel
//   done                one-cycle pulse when a triangle is finished
//   pix_count           pixels emitted for the last/current triangle
// -----------------------------------------------------------------------------
module tri_scan_unit #(
  parameter int  COORD_W   = 16,
  parameter int  SCREEN_W  = 320,
  parameter int  SCREEN_H  = 240,
  parameter int  CULL_BACK = 1,
  localparam int E_W       = 2 * COORD_W + 4,
  localparam int XW        = $clog2(SCREEN_W),
  localparam int YW        = $clog2(SCREEN_H),
  localparam int CNT_W     = $clog2(SCREEN_W * SCREEN_H + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] v0x,
  input  logic [COORD_W-1:0] v0y,
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic               done,
  output logic [CNT_W-1:0]   pix_count
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_SCAN, S_DONE} state_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [E_W-1:0]     edge_t;

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

  function automatic edge_t sext(input coord_t v);
    return {{(E_W - COORD_W){v[COORD_W-1]}}, v};
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_t            state_q, state_d;
  coord_t            vx_q [3], vx_d [3];
  coord_t            vy_q [3], vy_d [3];
  coord_t            xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t            ymin_q, ymin_d, ymax_q, ymax_d;
  edge_t             a_q [3], a_d [3];     // x-step per edge
  edge_t             b_q [3], b_d [3];     // y-step per edge
  edge_t             e_q [3], e_d [3];     // edge values at current pixel
  edge_t             row_q [3], row_d [3]; // edge values at current row start
  edge_t             area_q, area_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  coord_t mn_x, mx_x, mn_y, mx_y;
  logic   covered, box_empty, negate, skip;

  assign mn_x = min3(vx_q[0], vx_q[1], vx_q[2]);
  assign mx_x = max3(vx_q[0], vx_q[1], vx_q[2]);
  assign mn_y = min3(vy_q[0], vy_q[1], vy_q[2]);
  assign mx_y = max3(vy_q[0], vy_q[1], vy_q[2]);

  // Inclusive inside test: a pixel on an edge counts as covered.
  assign covered   = !e_q[0][E_W-1] && !e_q[1][E_W-1] && !e_q[2][E_W-1];
  // An entirely off-screen triangle clamps to an inverted box.
  assign box_empty = (xmax_q < xmin_q) || (ymax_q < ymin_q);
  // Clockwise triangles are flipped into the positive-area orientation.
  assign negate    = (CULL_BACK == 0) && area_q[E_W-1];
  assign skip      = (area_q == '0) || ((CULL_BACK != 0) && area_q[E_W-1]) || box_empty;

  // Outputs decode registered state only; pix_ready never reaches pix_valid.
  assign tri_ready = (state_q == S_IDLE);
  assign pix_valid = (state_q == S_SCAN) && covered;
  assign done      = (state_q == S_DONE);
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_count = cnt_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    row_d   = row_q;
    area_d  = area_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (tri_valid) begin
          vx_d[0] = v0x;
          vy_d[0] = v0y;
          vx_d[1] = v1x;
          vy_d[1] = v1y;
          vx_d[2] = v2x;
          vy_d[2] = v2y;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        xmin_d = mn_x[COORD_W-1] ? '0 : mn_x;
        ymin_d = mn_y[COORD_W-1] ? '0 : mn_y;
        xmax_d = (mx_x > X_LAST) ? X_LAST : mx_x;
        ymax_d = (mx_y > Y_LAST) ? Y_LAST : mx_y;
        for (int i = 0; i < 3; i++) begin
          a_d[i] = sext(vy_q[(i + 1) % 3]) - sext(vy_q[i]);
          b_d[i] = sext(vx_q[i]) - sext(vx_q[(i + 1) % 3]);
        end
        area_d = (sext(vx_q[2]) - sext(vx_q[0])) * (sext(vy_q[1]) - sext(vy_q[0]))
               - (sext(vy_q[2]) - sext(vy_q[0])) * (sext(vx_q[1]) - sext(vx_q[0]));
        state_d = S_INIT;
      end

      S_INIT: begin
        // E = (px-vix)*A + (py-viy)*B, with B already holding -(vjx-vix).
        for (int i = 0; i < 3; i++) begin
          e_d[i] = (sext(xmin_q) - sext(vx_q[i])) * a_q[i]
                 + (sext(ymin_q) - sext(vy_q[i])) * b_q[i];
          if (negate) begin
            e_d[i] = -e_d[i];
            a_d[i] = -a_q[i];
            b_d[i] = -b_q[i];
          end
          row_d[i] = e_d[i];
        end
        x_d     = xmin_q[XW-1:0];
        y_d     = ymin_q[YW-1:0];
        state_d = skip ? S_DONE : S_SCAN;
      end

      S_SCAN: begin
        if (!covered || pix_ready) begin
          if (covered) cnt_d = cnt_q + CNT_W'(1);
          if (x_q == xmax_q[XW-1:0]) begin
            if (y_q == ymax_q[YW-1:0]) begin
              state_d = S_DONE;
            end else begin
              x_d = xmin_q[XW-1:0];
              y_d = y_q + YW'(1);
              for (int i = 0; i < 3; i++) begin
                row_d[i] = row_q[i] + b_q[i];
                e_d[i]   = row_q[i] + b_q[i];
              end
            end
          end else begin
            x_d = x_q + XW'(1);
            for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + a_q[i];
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]  <= '0;
        vy_q[i]  <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        e_q[i]   <= '0;
        row_q[i] <= '0;
      end
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      area_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      row_q   <= row_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      area_q  <= area_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tri_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_tri_scan_unit
//
// Directed bench for tri_scan_unit on a 16x16 screen. Two instances share the
// clock and reset: u_dut_a culls back faces, u_dut_b rasterises both
// orientations. 'sel' routes the triangle handshake and the observed outputs
// to one of them. Expected pixel sequences and done cycles come from a small
// in-bench model of the row-major walk (covered iff x+y <= lim in the box).
// -----------------------------------------------------------------------------
module tb_tri_scan_unit;

  localparam int CW = 16;
  localparam int SW = 16;
  localparam int SH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          sel;
  logic          tri_valid;
  logic [CW-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic          pix_ready;

  logic       tri_valid_a, tri_ready_a, pix_valid_a, done_a;
  logic [3:0] pix_x_a, pix_y_a;
  logic [8:0] pix_count_a;
  logic       tri_valid_b, tri_ready_b, pix_valid_b, done_b;
  logic [3:0] pix_x_b, pix_y_b;
  logic [8:0] pix_count_b;

  logic       tri_ready, pix_valid, done;
  logic [3:0] pix_x, pix_y;
  logic [8:0] pix_count;

  assign tri_valid_a = tri_valid && !sel;
  assign tri_valid_b = tri_valid && sel;
  assign tri_ready   = sel ? tri_ready_b : tri_ready_a;
  assign pix_valid   = sel ? pix_valid_b : pix_valid_a;
  assign done        = sel ? done_b      : done_a;
  assign pix_x       = sel ? pix_x_b     : pix_x_a;
  assign pix_y       = sel ? pix_y_b     : pix_y_a;
  assign pix_count   = sel ? pix_count_b : pix_count_a;

  tri_scan_unit #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(1)) u_dut_a (
    .clk(clk), .rst(rst), .tri_valid(tri_valid_a), .tri_ready(tri_ready_a),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .pix_valid(pix_valid_a), .pix_ready(pix_ready), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .done(done_a), .pix_count(pix_count_a)
  );

  tri_scan_unit #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(0)) u_dut_b (
    .clk(clk), .rst(rst), .tri_valid(tri_valid_b), .tri_ready(tri_ready_b),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .done(done_b), .pix_count(pix_count_b)
  );

  int checks = 0;
  int errors = 0;
  int t_acc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tri_ready"}, tri_ready, 1);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_count"}, pix_count, 0);
  endtask

  // Called on a falling edge: offers the triangle in this cycle (cycle T) and
  // returns on the falling edge of T+1.
  task automatic send(input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input bit hold);
    v0x = CW'(x0); v0y = CW'(y0);
    v1x = CW'(x1); v1y = CW'(y1);
    v2x = CW'(x2); v2y = CW'(y2);
    tri_valid = 1'b1;
    t_acc = cyc;
    check("accept_tri_ready", tri_ready, 1);
    @(negedge clk);
    if (!hold) tri_valid = 1'b0;
    check("busy_tri_ready", tri_ready, 0);
  endtask

  // Observes one triangle. lim/bw/bh describe the expected coverage
  // (x+y <= lim inside a bw x bh box at the origin); has_pix=0 means the
  // triangle is expected to finish with no pixels at T+3.
  task automatic run(input string tag, input int lim, input int bw, input int bh,
                     input bit has_pix, input bit stall, input int abort_after,
                     output bit aborted);
    int  exp_q[$];
    int  c, got, bad, stall_bad, first, last, code;
    bit  seen_done, prev_stall;
    logic [3:0] sx, sy;

    aborted = 1'b0;
    c = t_acc + 3;
    if (has_pix) begin
      for (int y = 0; y < bh; y++) begin
        for (int x = 0; x < bw; x++) begin
          if (x + y <= lim) begin
            exp_q.push_back((x << 8) | y);
            if (stall) while (c % 3 != 0) c++;
          end
          c++;
        end
      end
    end

    got = 0; bad = 0; stall_bad = 0; first = -1; last = -1;
    seen_done = 1'b0; prev_stall = 1'b0; sx = '0; sy = '0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(negedge clk);
      pix_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (prev_stall && !(pix_valid === 1'b1 && pix_x === sx && pix_y === sy)) stall_bad++;
      prev_stall = pix_valid && !pix_ready;
      sx = pix_x;
      sy = pix_y;
      if (pix_valid && pix_ready) begin
        code = (int'(pix_x) << 8) | int'(pix_y);
        if (got >= exp_q.size() || code != exp_q[got]) bad++;
        if (got == 0) first = code;
        last = code;
        got++;
        if (abort_after != 0 && got == abort_after) begin
          aborted = 1'b1;
          return;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        tri_valid = 1'b0;
        check({tag, "_done_cycle"}, cyc - t_acc, c - t_acc);
      end
    end

    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_pix_emitted"}, got, exp_q.size());
    check({tag, "_seq_errors"}, bad, 0);
    check({tag, "_pix_count"}, pix_count, exp_q.size());
    if (exp_q.size() > 0) begin
      check({tag, "_first_pix"}, first, exp_q[0]);
      check({tag, "_last_pix"}, last, exp_q[exp_q.size() - 1]);
    end
    if (stall) check({tag, "_stall_stable"}, stall_bad, 0);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_ready_after"}, tri_ready, 1);
  endtask

  initial begin
    bit ab;
    rst = 1'b1; sel = 1'b0; tri_valid = 1'b0; pix_ready = 1'b1;
    v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic: 45 pixels with x+y<=8, box 9x9, done at T+84; valid held high.
    send(0, 0, 0, 8, 8, 0, 1'b1);
    run("basic", 8, 9, 9, 1'b1, 1'b0, 0, ab);

    // Swapped orientation, back-face culled.
    send(0, 0, 8, 0, 0, 8, 1'b0);
    run("cull", 0, 0, 0, 1'b0, 1'b0, 0, ab);

    // Swapped orientation on the non-culling instance: same 45 pixels.
    sel = 1'b1;
    send(0, 0, 8, 0, 0, 8, 1'b0);
    run("nocull", 8, 9, 9, 1'b1, 1'b0, 0, ab);
    sel = 1'b0;

    // Backpressure: pix_ready high one cycle in three.
    send(0, 0, 0, 8, 8, 0, 1'b0);
    run("stall", 8, 9, 9, 1'b1, 1'b1, 0, ab);
    pix_ready = 1'b1;

    // Clipping: box clamps to 0..15, 151 pixels with x+y<=16.
    send(-4, -4, -4, 20, 20, -4, 1'b0);
    run("clip", 16, 16, 16, 1'b1, 1'b0, 0, ab);

    // Degenerate, then the basic triangle offered at T+4.
    send(0, 0, 4, 4, 8, 8, 1'b0);
    run("degen", 0, 0, 0, 1'b0, 1'b0, 0, ab);
    send(0, 0, 0, 8, 8, 0, 1'b0);
    run("b2b", 8, 9, 9, 1'b1, 1'b0, 0, ab);

    // Reset after 10 emitted pixels, then a fresh triangle.
    send(0, 0, 0, 8, 8, 0, 1'b0);
    run("abort", 8, 9, 9, 1'b1, 1'b0, 10, ab);
    check("abort_reached", ab, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_no_done", done, 0);
    check("midrst_tri_ready", tri_ready, 1);
    rst = 1'b0;
    send(0, 0, 0, 8, 8, 0, 1'b0);
    run("after_rst", 8, 9, 9, 1'b1, 1'b0, 0, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
